conv_result_reader: RTL and testbench
=====================================

# conv_result_reader

Reads a completed convolution feature map out of the result BRAM written by the convolution engine and streams it downstream as requantized signed 8-bit pixels. It is the read-side counterpart of the engine's BRAM write port. It issues raster-order reads, absorbs the one-cycle BRAM read latency, and drives a valid/ready stream that feeds the next layer's pixel input (pooling or the next conv stage).

## Interface
- MAPSIZE, 32, input map edge; output map edge is OUT = MAPSIZE-4, with N = OUT*OUT entries (784 at default)
- SHIFT, 8, requantization right-shift amount (1..24)
- RELU, 1, 1 clamps negative results to 0; 0 keeps signed results
- ADDR_W, $clog2(N), read address width (derived; do not override)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous and active-low
- start  in  1  begin reading the map; sampled only in IDLE
- mem_rd_en  out  1  BRAM read strobe
- mem_rd_addr  out  ADDR_W  BRAM read address
- mem_rd_data  in  32 signed  BRAM data, valid exactly 1 cycle after mem_rd_en
- pixel_out  out  8 signed  requantized pixel
- data_valid_out  out  1  pixel_out valid
- ready_in  in  1  downstream accepts; a transfer occurs when data_valid_out && ready_in
- busy  out  1  high outside IDLE
- all_done  out  1  one-cycle pulse after the last transfer

## Operation
- States:
  - IDLE: start moves to READ with rd_ctr=0.
  - READ: issues reads; moves to DRAIN after the read of address N-1 is issued.
  - DRAIN: waits until the FIFO is empty and no read is in flight, then moves to DONE.
  - DONE: pulses all_done for one cycle, then returns to IDLE.
- start is ignored outside IDLE.
- Reads cover addresses 0..N-1 in order, one per cycle at most. mem_rd_addr = rd_ctr while mem_rd_en is high.
- Output buffering is a 2-entry FIFO that captures mem_rd_data the cycle after each read.
- Credit rule: issue a read only when fifo_count + inflight − (transfer this cycle) < 2. The FIFO must never overflow, and no read is ever dropped or repeated.
- Requantization (combinational on capture):
  - t = mem_rd_data + (1<<(SHIFT-1)), computed in 33 bits.
  - s = t >>> SHIFT (arithmetic).
  - Saturate s to [-128, 127].
  - If RELU, a negative result becomes 0.
- pixel_out and data_valid_out come from the FIFO head. Once asserted, data_valid_out stays high and pixel_out stays stable until the transfer.
- Reset, async at any time:
  - State returns to IDLE; counters and FIFO clear.
  - The in-flight read is discarded.
  - All outputs go to 0 immediately.
- Reset values: mem_rd_en=0, mem_rd_addr=0, pixel_out=0, data_valid_out=0, busy=0, all_done=0.

## Timing
- The start-sample edge is edge 0.
- Edge 1: busy=1, mem_rd_en=1, addr=0.
- Cycle 2: mem_rd_data is valid; it is captured at edge 2.
- After edge 2: data_valid_out=1 with pixel 0, so first-valid latency is 2 cycles after start is sampled.
- With ready_in held high the stream is one pixel per cycle with no bubbles: N consecutive valid cycles, and mem_rd_en high for N consecutive cycles.
- all_done is high for the single cycle following the edge of the last transfer. busy falls with all_done's deassertion (the return to IDLE).
- While ready_in is low and the FIFO is full, mem_rd_en=0 and rd_ctr holds.
- After ready_in rises, the first new read issues in that same cycle (credit frees on the transfer).
- mem_rd_addr wraps never; the counter stops at N-1.
- A start arriving in the DONE cycle is ignored. A start in the following IDLE cycle is accepted.

## Test plan
- MAPSIZE=8 (N=16), SHIFT=8, RELU=0, mem[i]=i*256, ready_in=1 -> pixel_out 0..15 on 16 consecutive valid cycles. First valid comes 2 cycles after start; all_done pulses exactly once, 1 cycle after pixel 15.
- Requant corners, SHIFT=8:
  - 40000 -> 127; -40000 -> -128 (RELU=0) or 0 (RELU=1).
  - 383 -> 1; 127 -> 0; 128 -> 1; -129 -> -1 (RELU=0).
- Backpressure: ready_in low for 5 cycles at pixel 6 -> pixel_out holds 6 stable. At most 2 reads are issued past the last transfer, and the stream resumes 6,7,8… with no loss or duplicate.
- Random ready_in (50%) over N=784 default -> exactly 784 transfers in raster order matching the requant model. The FIFO never exceeds 2 entries.
- rst_n pulled low mid-cycle at pixel 7 -> all outputs 0 asynchronously. A subsequent start restarts from address 0 with pixel 0 first.
- start pulsed during READ and in the DONE cycle -> no effect. start one cycle after DONE -> a full second pass with identical output.

Source files
------------

// File: rtl/conv_result_reader.sv
// conv_result_reader: streams a finished convolution feature map out of the result
// BRAM in raster order, requantizing each 32-bit accumulator to a signed 8-bit pixel.
// A 2-entry FIFO absorbs the 1-cycle BRAM latency. Reads are credit-limited so the
// FIFO can never overflow.
module conv_result_reader #(
   parameter int unsigned MAPSIZE = 32,
   parameter int unsigned SHIFT   = 8,
   parameter int unsigned RELU    = 1,
   parameter int unsigned ADDR_W  = $clog2((MAPSIZE - 4) * (MAPSIZE - 4))
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   output logic                mem_rd_en,
   output logic [ADDR_W-1:0]   mem_rd_addr,
   input  logic signed [31:0]  mem_rd_data,
   output logic signed [7:0]   pixel_out,
   output logic                data_valid_out,
   input  logic                ready_in,
   output logic                busy,
   output logic                all_done
);

   localparam int unsigned N = (MAPSIZE - 4) * (MAPSIZE - 4);
   localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(N - 1);
   localparam logic signed [32:0] Round = 33'sd1 <<< (SHIFT - 1);

   typedef enum logic [1:0] {StIdle, StRead, StDrain, StDone} state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] rd_ctr_q, rd_ctr_d;
   logic              inflight_q;
   logic signed [7:0] fifo_q [2];
   logic              wr_ptr_q, rd_ptr_q;
   logic [1:0]        count_q;

   logic              fifo_valid, xfer, cap, credit, rd_issue;
   logic [2:0]        occ;
   logic signed [32:0] req_t, req_s;
   logic signed [7:0] req_pix;

   // Credit: occupancy counts FIFO entries plus the read in flight; a transfer this
   // cycle frees a slot immediately so full throughput needs no bubble.
   always_comb begin
      fifo_valid = (count_q != 2'd0);
      xfer       = fifo_valid && ready_in;
      cap        = inflight_q;
      occ        = {1'b0, count_q} + {2'b00, inflight_q};
      credit     = occ < (3'd2 + {2'b00, xfer});
      rd_issue   = (state_q == StRead) && credit;
   end

   // Requantize the BRAM word: round, arithmetic shift, saturate, optional ReLU.
   always_comb begin
      req_t = $signed({mem_rd_data[31], mem_rd_data}) + Round;
      req_s = req_t >>> SHIFT;
      if (req_s > 33'sd127) begin
         req_pix = 8'sd127;
      end else if (req_s < -33'sd128) begin
         req_pix = -8'sd128;
      end else begin
         req_pix = req_s[7:0];
      end
      if (RELU != 0 && req_pix < 0) begin
         req_pix = 8'sd0;
      end
   end

   // State register, read counter and in-flight flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         rd_ctr_q   <= '0;
         inflight_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         rd_ctr_q   <= rd_ctr_d;
         inflight_q <= rd_issue;
      end
   end

   // Output FIFO: capture the cycle after each read, pop on transfer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fifo_q   <= '{default: '0};
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (cap) begin
            fifo_q[wr_ptr_q] <= req_pix;
            wr_ptr_q         <= ~wr_ptr_q;
         end
         if (xfer) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         case ({cap, xfer})
            2'b10:   count_q <= count_q + 2'd1;
            2'b01:   count_q <= count_q - 2'd1;
            default: ;
         endcase
      end
   end

   // Next-state logic; the counter parks at the last address and never wraps.
   always_comb begin
      state_d  = state_q;
      rd_ctr_d = rd_ctr_q;
      case (state_q)
         StIdle: begin
            if (start) begin
               state_d  = StRead;
               rd_ctr_d = '0;
            end
         end
         StRead: begin
            if (rd_issue) begin
               if (rd_ctr_q == LastAddr) begin
                  state_d = StDrain;
               end else begin
                  rd_ctr_d = rd_ctr_q + 1'b1;
               end
            end
         end
         StDrain: begin
            // Leave as the last pixel transfers so all_done follows it directly.
            if (!inflight_q && (count_q == 2'd0 || (count_q == 2'd1 && xfer))) begin
               state_d = StDone;
            end
         end
         StDone: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Outputs: all derive from reset-cleared state, so reset zeroes them at once.
   always_comb begin
      busy           = (state_q != StIdle);
      all_done       = (state_q == StDone);
      mem_rd_en      = rd_issue;
      mem_rd_addr    = rd_ctr_q;
      data_valid_out = fifo_valid;
      pixel_out      = fifo_valid ? fifo_q[rd_ptr_q] : 8'sd0;
   end

endmodule

// File: tb/tb_conv_result_reader.sv
// Bench for conv_result_reader: two instances (8x8 map without ReLU, 32x32 map with
// ReLU), BRAM models, a queue scoreboard fed at start time and a negedge monitor.
module tb_conv_result_reader;

   localparam int NA = 16;
   localparam int NB = 784;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic              start_s [2];
   logic              rdy     [2];
   logic              ren     [2];
   logic              vld     [2];
   logic              busy    [2];
   logic              done    [2];
   logic signed [7:0] pix     [2];
   logic [3:0]        addr_a;
   logic [9:0]        addr_b;
   logic signed [31:0] rdata_a, rdata_b;

   int mem0 [NA];
   int mem1 [NB];
   int q0 [$];
   int q1 [$];
   int total = 0;
   int bad = 0;

   int next_addr [2];
   int outst     [2];
   int due       [2];
   logic              hold     [2];
   logic signed [7:0] hold_pix [2];

   int cval [6] = '{40000, -40000, 383, 127, 128, -129};
   int e0   [6] = '{127, -128, 1, 0, 1, -1};
   int e1   [6] = '{127, 0, 1, 0, 1, 0};

   conv_result_reader #(.MAPSIZE(8), .SHIFT(8), .RELU(0)) u_a (
      .clk(clk), .rst_n(rst_n), .start(start_s[0]),
      .mem_rd_en(ren[0]), .mem_rd_addr(addr_a), .mem_rd_data(rdata_a),
      .pixel_out(pix[0]), .data_valid_out(vld[0]), .ready_in(rdy[0]),
      .busy(busy[0]), .all_done(done[0])
   );

   conv_result_reader #(.MAPSIZE(32), .SHIFT(8), .RELU(1)) u_b (
      .clk(clk), .rst_n(rst_n), .start(start_s[1]),
      .mem_rd_en(ren[1]), .mem_rd_addr(addr_b), .mem_rd_data(rdata_b),
      .pixel_out(pix[1]), .data_valid_out(vld[1]), .ready_in(rdy[1]),
      .busy(busy[1]), .all_done(done[1])
   );

   always @(posedge clk) if (ren[0]) rdata_a <= mem0[addr_a];
   always @(posedge clk) if (ren[1]) rdata_b <= mem1[addr_b];

   // Reference: round-to-nearest divide by 256 (floor of (v+128)/256), clamp, ReLU.
   function automatic int requant(input int v, input bit relu);
      longint t, s;
      t = longint'(v) + 128;
      if (t >= 0) s = t / 256;
      else s = -((-t + 255) / 256);
      if (s > 127) s = 127;
      if (s < -128) s = -128;
      if (relu && s < 0) s = 0;
      return int'(s);
   endfunction

   function automatic int rnd_val();
      case ($urandom_range(0, 2))
         0: return int'($urandom);
         1: return int'($urandom_range(0, 600)) - 300;
         default: return int'($urandom_range(0, 80000)) - 40000;
      endcase
   endfunction

   task automatic check(input string name, input int d, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s dut%0d: got %0d expected %0d at %0t", name, d, act, exp, $time);
      end
   endtask

   task automatic chk_zero(input int d);
      check("rst_rd_en", d, ren[d], 0);
      check("rst_rd_addr", d, d ? longint'(addr_b) : longint'(addr_a), 0);
      check("rst_pixel", d, pix[d], 0);
      check("rst_valid", d, vld[d], 0);
      check("rst_busy", d, busy[d], 0);
      check("rst_all_done", d, done[d], 0);
   endtask

   task automatic push_pass(input int d, input bit tbl);
      int n = d ? NB : NA;
      int v, e;
      next_addr[d] = 0;
      for (int i = 0; i < n; i++) begin
         v = d ? mem1[i] : mem0[i];
         e = (tbl && i < 6) ? (d ? e1[i] : e0[i]) : requant(v, d == 1);
         if (d != 0) q1.push_back(e);
         else q0.push_back(e);
      end
   endtask

   task automatic start_pass(input int d);
      @(posedge clk); #1 start_s[d] = 1'b1;
      @(posedge clk); #1 start_s[d] = 1'b0;
   endtask

   task automatic wait_done(input int d, input bit rnd, input int budget);
      for (int c = 0; c < budget; c++) begin
         @(posedge clk); #1;
         if (done[d]) return;
         if (rnd) rdy[d] = 1'($urandom_range(0, 1));
      end
      total++;
      bad++;
      $display("FAIL wait_done dut%0d: got no all_done expected one within %0d cycles", d, budget);
   endtask

   task automatic wait_pix(input int d, input int val, input int budget);
      for (int c = 0; c < budget; c++) begin
         @(negedge clk);
         if (vld[d] && pix[d] == 8'(val)) return;
      end
      total++;
      bad++;
      $display("FAIL wait_pixel dut%0d: got no pixel expected %0d within %0d cycles", d, val,
               budget);
   endtask

   // Monitor: looks at the cycle about to end at the next rising edge.
   task automatic mon_step(input int d);
      int e, a, qs;
      if (!rst_n) begin
         next_addr[d] = 0;
         outst[d]     = 0;
         due[d]       = 0;
         hold[d]      = 1'b0;
         return;
      end
      a = d ? int'(addr_b) : int'(addr_a);
      check("all_done", d, done[d], due[d] == 1);
      if (due[d] == 1) begin
         due[d] = 2;
      end else if (due[d] == 2) begin
         check("busy_after_done", d, busy[d], 0);
         due[d] = 0;
      end
      if (hold[d]) begin
         check("hold_valid", d, vld[d], 1);
         check("hold_pixel", d, pix[d], hold_pix[d]);
      end
      hold[d]     = vld[d] && !rdy[d];
      hold_pix[d] = pix[d];
      if (ren[d]) begin
         check("rd_addr", d, a, next_addr[d]);
         next_addr[d]++;
         outst[d]++;
      end
      if (vld[d] && rdy[d]) begin
         qs = d ? q1.size() : q0.size();
         if (qs == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_pixel dut%0d: got %0d expected no transfer", d, pix[d]);
         end else begin
            e = (d != 0) ? q1.pop_front() : q0.pop_front();
            check("pixel", d, pix[d], e);
            if (qs == 1) due[d] = 1;
         end
         outst[d]--;
      end
      check("outstanding_le2", d, outst[d] <= 2, 1);
   endtask

   always @(negedge clk) begin
      mon_step(0);
      mon_step(1);
   end

   logic [20:0] ren_v, vld_v, done_v, busy_v;
   logic [20:0] ren_e, vld_e, done_e, busy_e;

   initial begin
      rst_n = 1'b0;
      for (int d = 0; d < 2; d++) begin
         start_s[d] = 1'b0;
         rdy[d]     = 1'b1;
      end
      for (int i = 0; i < NA; i++) mem0[i] = i * 256;
      for (int i = 0; i < NB; i++) mem1[i] = (i < 6) ? cval[i] : rnd_val();
      #12;
      chk_zero(0);
      chk_zero(1);
      #5 rst_n = 1'b1;
      repeat (2) @(posedge clk);

      // Full-rate pass: latency, no bubbles, all_done placement.
      push_pass(0, 1'b0);
      @(posedge clk); #1 start_s[0] = 1'b1;
      for (int k = 0; k < 21; k++) begin
         @(posedge clk); #1;
         if (k == 0) start_s[0] = 1'b0;
         ren_v[k]  = ren[0];
         vld_v[k]  = vld[0];
         done_v[k] = done[0];
         busy_v[k] = busy[0];
         ren_e[k]  = (k <= 15);
         vld_e[k]  = (k >= 2 && k <= 17);
         done_e[k] = (k == 18);
         busy_e[k] = (k <= 18);
         if (k == 0) check("first_addr", 0, addr_a, 0);
         if (k == 1) check("second_addr", 0, addr_a, 1);
         if (k == 2) check("first_pixel", 0, pix[0], 0);
      end
      check("rd_en_pattern", 0, ren_v, ren_e);
      check("valid_pattern", 0, vld_v, vld_e);
      check("done_pattern", 0, done_v, done_e);
      check("busy_pattern", 0, busy_v, busy_e);

      // Backpressure at pixel 6.
      push_pass(0, 1'b0);
      start_pass(0);
      wait_pix(0, 5, 50);
      @(posedge clk); #1 rdy[0] = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check("bp_rd_en_off", 0, ren[0], 0);
      check("bp_pixel", 0, pix[0], 6);
      check("bp_valid", 0, vld[0], 1);
      rdy[0] = 1'b1;
      #1 check("bp_resume_read", 0, ren[0], 1);
      wait_done(0, 1'b0, 100);

      // Asynchronous reset mid-stream, then a clean restart.
      push_pass(0, 1'b0);
      start_pass(0);
      wait_pix(0, 7, 50);
      @(posedge clk); #3 rst_n = 1'b0;
      #1 chk_zero(0);
      q0.delete();
      @(posedge clk); #3 rst_n = 1'b1;
      push_pass(0, 1'b0);
      start_pass(0);
      wait_done(0, 1'b0, 100);

      // start during READ and in DONE ignored; start right after DONE accepted.
      push_pass(0, 1'b0);
      start_pass(0);
      repeat (3) @(posedge clk);
      #1 start_s[0] = 1'b1;
      @(posedge clk); #1 start_s[0] = 1'b0;
      wait_done(0, 1'b0, 100);
      start_s[0] = 1'b1;
      @(posedge clk); #1;
      check("done_cycle_start_ignored", 0, busy[0], 0);
      push_pass(0, 1'b0);
      @(posedge clk); #1 start_s[0] = 1'b0;
      check("start_after_done", 0, busy[0], 1);
      wait_done(0, 1'b0, 100);

      // Requant corners and random data under random ready, small map.
      for (int i = 0; i < NA; i++) mem0[i] = (i < 6) ? cval[i] : rnd_val();
      push_pass(0, 1'b1);
      start_pass(0);
      wait_done(0, 1'b1, 400);
      rdy[0] = 1'b1;

      // Full-size map with ReLU under random ready.
      push_pass(1, 1'b1);
      start_pass(1);
      wait_done(1, 1'b1, 6000);
      rdy[1] = 1'b1;

      repeat (5) @(posedge clk);
      check("leftover_a", 0, q0.size(), 0);
      check("leftover_b", 1, q1.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
